// File: rtl/sort_engine_4.sv
// Four-value unsigned bubble sorter: one compare-and-swap per cycle, six compares per sort.
// Optional early exit on a swap-free pass is enabled by defining SORT_EARLY_EXIT_EN.
module sort_engine_4 #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] c,
  input  logic [n-1:0] d,
  output logic [n-1:0] s0,
  output logic [n-1:0] s1,
  output logic [n-1:0] s2,
  output logic [n-1:0] s3,
  output logic         busy,
  output logic         done,
  output logic         valid
);

  // state | meaning
  // IDLE  | waiting for start; s0..s3 hold the last result
  // SORT  | one adjacent compare-and-swap per cycle
  // DONE  | single cycle with done high, then back to IDLE
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t       state, state_nxt;
  logic [n-1:0] r     [4];
  logic [n-1:0] r_nxt [4];
  logic [1:0]   pass, idx, idx_hi;
  logic         swap_now, pass_end, finish;
`ifdef SORT_EARLY_EXIT_EN
  logic         swapped;
`endif

  always_comb begin
    idx_hi   = idx + 2'd1;
    swap_now = r[idx] > r[idx_hi];
    r_nxt    = r;
    if (swap_now) begin
      r_nxt[idx]    = r[idx_hi];
      r_nxt[idx_hi] = r[idx];
    end
    // pass p covers j = 0 .. 2-p
    pass_end = (idx == (2'd2 - pass));
`ifdef SORT_EARLY_EXIT_EN
    finish   = pass_end && ((pass == 2'd2) || !(swapped || swap_now));
`else
    finish   = pass_end && (pass == 2'd2);
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = SORT;
      SORT: begin
        busy = 1'b1;
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) r[i] <= '0;
      s0    <= '0;
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      pass  <= '0;
      idx   <= '0;
      valid <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
      swapped <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          r[0]  <= a;
          r[1]  <= b;
          r[2]  <= c;
          r[3]  <= d;
          pass  <= '0;
          idx   <= '0;
          valid <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
          swapped <= 1'b0;
`endif
        end
        SORT: begin
          for (int i = 0; i < 4; i++) r[i] <= r_nxt[i];
          if (finish) begin
            s0    <= r_nxt[0];
            s1    <= r_nxt[1];
            s2    <= r_nxt[2];
            s3    <= r_nxt[3];
            valid <= 1'b1;
          end else if (pass_end) begin
            pass <= pass + 2'd1;
            idx  <= '0;
`ifdef SORT_EARLY_EXIT_EN
            swapped <= 1'b0;
`endif
          end else begin
            idx <= idx + 2'd1;
`ifdef SORT_EARLY_EXIT_EN
            swapped <= swapped | swap_now;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sort_engine_4.md
SORT_ENGINE_4 -- requirements
Module: sort_engine_4

Interface
REQ-001 SHALL have parameter: n, 8, data width of each value in bits.
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on posedge clk.
REQ-003 SHALL have port: clr  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to sort; sampled on posedge clk, acted on only in IDLE.
REQ-005 SHALL have ports: a, b, c, d  input  n each  unsorted operands, captured on an accepted start.
REQ-006 SHALL have ports: s0, s1, s2, s3  output  n each  sorted result; s0 is the smallest, s3 the largest.
REQ-007 SHALL have port: busy  output  1  high while in SORT.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when a new result appears on s0..s3.
REQ-009 SHALL have port: valid  output  1  high when s0..s3 hold a completed result.

Function
REQ-010 SHALL implement states IDLE, SORT and DONE as an FSM.
REQ-011 IDLE with start=1 at edge E0 SHALL capture a..d into working registers r0..r3, clear the pass and index counters, enter SORT, set busy=1 and clear valid.
REQ-012 SORT SHALL perform one compare-and-swap per cycle on the adjacent pair r[j], r[j+1], swapping only when r[j] > r[j+1] (unsigned).
REQ-013 Equal values SHALL NOT swap, so the sort is stable.
REQ-014 SHALL sequence passes as bubble sort: pass 0 uses j=0,1,2; pass 1 uses j=0,1; pass 2 uses j=0; total 6 compare cycles at E1..E6.
REQ-015 On the final compare edge, s0..s3 SHALL load the post-swap r0..r3 and the FSM SHALL enter DONE.
REQ-016 On that same edge done and valid SHALL be set to 1 and busy cleared.
REQ-017 s0..s3 SHALL NOT show intermediate values and SHALL hold the previous result throughout SORT.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE with done=0 and valid held at 1.
REQ-019 Latency SHALL be 7 cycles: done is high during the cycle after E6.
REQ-020 start asserted in SORT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-021 start held high continuously SHALL begin a new sort on each IDLE visit, i.e. every 8 cycles.
REQ-022 a..d changing after E0 SHALL NOT affect the sort in progress.

Reset
REQ-023 clr=1 SHALL immediately, without waiting for a clock edge, force state IDLE, r0..r3=0, s0..s3=0, counters=0, busy=0, done=0 and valid=0.
REQ-024 clr asserted mid-sort SHALL abort the sort with no done pulse.
REQ-025 The first accepted start after clr deasserts SHALL behave per REQ-011.
REQ-026 clr SHALL take priority over start on the same edge.

Configuration
REQ-027 Macro SORT_EARLY_EXIT_EN, when defined, SHALL track a per-pass swap flag; a pass 0 or pass 1 that completes with no swap SHALL finish immediately per REQ-015/016.
REQ-028 With SORT_EARLY_EXIT_EN defined, minimum latency SHALL be 4 cycles: done in the cycle after E3.
REQ-029 With SORT_EARLY_EXIT_EN undefined, latency SHALL always be 7 cycles and no swap flag logic SHALL exist.
REQ-030 Sorted output values SHALL be identical in both configurations.

Verification
REQ-031 Scenario: a,b,c,d=8'h40,8'h10,8'h30,8'h20, start pulse -> s0..s3=10,20,30,40, done high one cycle, 7 cycles after E0, valid=1 afterwards.
REQ-032 Scenario: inputs FF,00,FF,00 -> s0..s3=00,00,FF,FF; already-sorted 01,02,03,04 -> unchanged, with latency 7 without the macro and 4 with SORT_EARLY_EXIT_EN.
REQ-033 Scenario: start re-pulsed at E2 and E5 during a sort -> single done pulse; s0..s3 match the first operand set only.
REQ-034 Scenario: clr pulsed between clock edges at E3 -> outputs and flags zero immediately, no done pulse; the next start sorts 04,03,02,01 -> 01,02,03,04.
REQ-035 Scenario: start tied high with alternating operand sets -> done every 8 cycles, each result correct; a..d changed at E1 have no effect on the current sort.
